// File: rtl/blink_monitor.sv
// Measures the toggle interval of an asynchronous blinking signal, locks once
// enough consecutive intervals are in tolerance, and latches a fault otherwise.
module blink_monitor #(
  parameter int FREQ     = 50000000,
  parameter int SECS     = 1,
  parameter int TOL      = 1000,
  parameter int LOCK_CNT = 2,
  parameter int W        = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         led_i,
  input  logic         clear_i,
  output logic         locked_o,
  output logic         error_o,
  output logic [W-1:0] period_o,
  output logic         valid_o
);

  localparam longint NL = longint'(FREQ) * longint'(SECS);
  localparam int     GW = $clog2(LOCK_CNT + 1);

  // Limits are held at W+1 bits so N+TOL+1 cannot wrap.
  localparam logic [W:0]    LO_LIM = (W+1)'(NL - longint'(TOL));
  localparam logic [W:0]    HI_LIM = (W+1)'(NL + longint'(TOL));
  localparam logic [W:0]    TO_LIM = (W+1)'(NL + longint'(TOL) + 1);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_CNT);

  if (NL < 4 || longint'(TOL) >= NL || NL + longint'(TOL) >= (longint'(1) << W) ||
      LOCK_CNT == 0) begin : g_bad_params
    initial $stop;
  end

  typedef enum logic [1:0] {SEEK, TRACK, LOCKED, FAULT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          led_q, led_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [GW-1:0] good_q, good_d;
  logic [W-1:0]  period_q, period_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          error_q, error_d;

  logic          edge_w;
  logic [W:0]    interval;
  logic          in_range;

  assign edge_w   = sync_q[1] ^ led_q;
  assign interval = {1'b0, cnt_q} + (W+1)'(1);
  assign in_range = (interval >= LO_LIM) && (interval <= HI_LIM);

  always_comb begin
    sync_d   = {sync_q[0], led_i};
    led_d    = sync_q[1];
    state_d  = state_q;
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + W'(1);
    good_d   = good_q;
    period_d = period_q;
    valid_d  = 1'b0;
    if (clear_i) begin
      state_d = SEEK;
      cnt_d   = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        SEEK: begin
          if (edge_w) begin
            state_d = TRACK;
            cnt_d   = '0;
            good_d  = '0;
          end
        end
        TRACK, LOCKED: begin
          if (edge_w) begin
            cnt_d    = '0;
            period_d = interval[W-1:0];
            valid_d  = 1'b1;
            if (in_range) begin
              if (good_q != LOCK_G) good_d = good_q + GW'(1);
              if (state_q == TRACK && good_d == LOCK_G) state_d = LOCKED;
            end else begin
              state_d = FAULT;
            end
          end else if (interval == TO_LIM) begin
            state_d = FAULT;
          end
        end
        default: ;
      endcase
    end
    locked_d = (state_q == LOCKED);
    error_d  = (state_q == FAULT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= SEEK;
      sync_q   <= '0;
      led_q    <= 1'b0;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      led_q    <= led_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  assign locked_o = locked_q;
  assign error_o  = error_q;
  assign period_o = period_q;
  assign valid_o  = valid_q;

endmodule

// File: doc/blink_monitor.md
BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 SHALL have parameter FREQ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter SECS, default 1, expected seconds between toggles of the monitored signal.
REQ-003 SHALL have parameter TOL, default 1000, allowed deviation in cycles from the nominal interval N = FREQ*SECS.
REQ-004 SHALL have parameter LOCK_CNT, default 2, consecutive in-tolerance intervals needed to lock.
REQ-005 SHALL have parameter W, default 32, width of the interval counter and period_o.
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 SHALL have port clk_i, input, 1, sole clock.
REQ-008 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-009 SHALL have port led_i, input, 1, asynchronous blinking signal under test.
REQ-010 SHALL have port clear_i, input, 1, single-cycle fault clear and restart.
REQ-011 SHALL have port locked_o, output, 1, high while in LOCKED.
REQ-012 SHALL have port error_o, output, 1, high while in FAULT.
REQ-013 SHALL have port period_o, output, W, last measured interval in cycles.
REQ-014 SHALL have port valid_o, output, 1, one-cycle pulse when period_o updates.

Function
REQ-015 SHALL synchronize led_i through a 2-flop chain, register the synchronized value, and detect an edge (either polarity) when the synchronized value differs from the registered value.
REQ-016 SHALL register valid_o and period_o, so an edge is reported 3 cycles after led_i is first sampled changed.
REQ-017 SHALL clear the counter cnt to 0 on each edge cycle and increment it on every other cycle, saturating at 2^W-1.
REQ-018 SHALL compute the measured interval at an edge as cnt+1 (edges N cycles apart give N).
REQ-019 SHALL implement the states SEEK, TRACK, LOCKED and FAULT, with reset state SEEK.
REQ-020 SEEK: SHALL have no timeout and no period_o update; the first edge SHALL transition to TRACK and clear cnt and good_cnt.
REQ-021 TRACK/LOCKED edge handling SHALL update period_o to the interval and pulse valid_o.
REQ-022 TRACK/LOCKED in-range interval: if the interval lies in [N-TOL, N+TOL] inclusive, good_cnt SHALL increment, saturating at LOCK_CNT.
REQ-023 TRACK/LOCKED out-of-range interval: any other interval SHALL transition to FAULT.
REQ-024 TRACK SHALL transition to LOCKED in the cycle good_cnt reaches LOCK_CNT.
REQ-025 TRACK/LOCKED timeout: if there is no edge and cnt+1 = N+TOL+1, SHALL transition to FAULT; period_o is not updated and valid_o stays low.
REQ-026 FAULT SHALL be sticky: edges are ignored and period_o holds its value until clear_i.
REQ-027 clear_i in any state SHALL transition to SEEK and clear cnt and good_cnt, with period_o holding its value.
REQ-028 clear_i and an edge in the same cycle SHALL give priority to clear_i, ignore the edge, and leave valid_o low.
REQ-029 SHALL perform interval comparisons at W+1 bits so that N+TOL cannot overflow.
REQ-030 SHALL derive locked_o and error_o as registered decodes of state, never both high.
REQ-031 SHALL fail elaboration ($stop in an initial block) if N < 4, TOL >= N, N+TOL >= 2^W, or LOCK_CNT = 0.

Reset
REQ-032 In the cycle rst_i is high, SHALL reset the state to SEEK; sync chain, edge register, cnt, good_cnt, period_o, valid_o, locked_o and error_o to 0.
REQ-033 SHALL treat a led_i that is high at reset release as a rising edge, detected as the first edge in SEEK.
REQ-034 SHALL have rst_i take priority over clear_i and edges.
REQ-035 SHALL discard any partially measured interval when reset is asserted mid-operation.

Verification (FREQ=10, SECS=1, TOL=1, LOCK_CNT=2, W=8; N=10)
REQ-036 Toggle led_i every 10 cycles -> valid_o pulses with period_o=10; locked_o=1 after the 2nd measured interval; error_o=0.
REQ-037 Intervals 9, 11, 9, 11 -> all accepted; locked_o stays 1 with period_o tracking 9/11.
REQ-038 Interval 8 while LOCKED -> period_o=8, valid_o pulse, error_o=1 next cycle, locked_o=0; further toggles ignored.
REQ-039 led_i held constant in TRACK -> error_o=1 when cnt+1 reaches 12, with no valid_o; in SEEK, led_i held constant for 100 cycles -> no error.
REQ-040 In FAULT, clear_i asserted in the same cycle as an edge -> SEEK, error_o=0, no valid_o; the next edge enters TRACK.
REQ-041 rst_i mid-LOCKED with led_i=1 -> all outputs 0; edge detected 3 cycles after release starts TRACK; relock after 2 good intervals.
